cmd_rsp_deserializer: RTL and testbench
=======================================

# cmd_rsp_deserializer

- Receives SD-bus command-line responses (48-bit short, 136-bit long) bit-serially on the sd_clk sampling strobe.
- Computes and checks CRC7 and end bit, and presents the stripped payload to the command sequencer in `cmd_wrap`.
- Sits between the CMD pad input and the sequencer's response/error register update logic.
- The sequencer owns response timeout; this block waits for a start bit indefinitely.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  system clock; all flops on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- clk_en_i  in  1  sampling strobe, high in the clk_i cycle before the sd_clk posedge; every sequential update is gated by it.
- cmd_i  in  1  CMD line level.
- long_rsp_i  in  1  1 = 136-bit response (R2), 0 = 48-bit; sampled when armed.
- start_listening_i  in  1  arm request (level, qualified by clk_en_i).
- receiving_o  out  1  high while a frame is being shifted in (start bit seen, end bit not yet).
- rsp_valid_o  out  1  high for exactly one enabled period after the end bit is sampled.
- end_bit_err_o  out  1  sampled end bit was 0; valid with rsp_valid_o, held after.
- rsp_o  out  120  payload; held until next arm.
- crc_corr_o  out  1  received CRC7 equals computed CRC7; valid with rsp_valid_o, held after.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE. Transitions occur only on cycles with clk_en_i=1.
- start_listening_i=1 on an enabled cycle, from any state, moves to WAIT_START, has priority over all other transitions, and:
  - latches long_rsp_i;
  - clears the bit counter, shift register and CRC;
  - sets rsp_o=0, end_bit_err_o=0, crc_corr_o=0.
- WAIT_START: cmd_i=0 moves to RECEIVE with bit counter=1. cmd_i=1 stays.
- RECEIVE: shifts cmd_i into an MSB-first shift register and increments the 8-bit counter per enabled cycle. Frame length is N=48 (short) or N=136 (long), counting the start bit. When the sample at count N-1 (the end bit) is taken, the state moves to DONE.
- DONE: rsp_valid_o=1 for this one period, then IDLE.
- Bit numbering: bit N-1 is the start bit, bit 0 is the end bit.
- Short frame:
  - rsp_o[37:0] = R[45:8], i.e. [37:32] = index, [31:0] = card status.
  - rsp_o[119:38] = 0.
  - CRC input is R[47:8]; R[7:1] is the received CRC.
- Long frame:
  - rsp_o[119:0] = R[127:8]; the CRC and the reserved bits [135:128] are stripped.
  - CRC input is R[127:8]; R[7:1] is the received CRC.
- CRC7: polynomial x^7+x^3+1, seed 0, serial LFSR, updated only on bits in the CRC input range.
- Transmission bit and reserved bits are not checked.
- end_bit_err_o = ~R[0], registered on the end-bit sample.
- start_listening_i held high across several enabled cycles keeps re-arming; a start bit is only accepted on the first enabled cycle with start_listening_i=0.

## Timing
- Reset values: state IDLE, receiving_o 0, rsp_valid_o 0, end_bit_err_o 0, rsp_o 0, crc_corr_o 0.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values.
- All outputs are registered and change only in the clk_i cycle after an enabled edge.
- receiving_o rises after the start-bit sample and falls together with the rise of rsp_valid_o.
- Latency: rsp_valid_o rises one clk_i cycle after the enabled cycle sampling bit 0. It falls one clk_i cycle after the next enabled cycle.
- With clk_en_i=1 every cycle:
  - short frame: start bit at enabled cycle k, rsp_valid_o high during cycle k+48 only;
  - long frame: rsp_valid_o high during cycle k+136 only.
- Re-arm in RECEIVE aborts the frame without asserting rsp_valid_o.
- cmd_i glitches between enabled cycles are ignored.

## Configuration
- `SDHCI_RSP_CRC_CHECK_EN`
  - Defined: CRC7 LFSR and comparison are built as above.
  - Undefined: CRC logic is removed and crc_corr_o is driven 1 whenever rsp_valid_o is asserted or held. The 0 after reset/arm is unchanged.

## Test plan
- Short, clk_en_i every cycle: arm, 3 idle 1s, then frame 0x48000001AA87 →
  - receiving_o high 47 cycles;
  - rsp_valid_o 1 cycle;
  - rsp_o[37:0] = 0x08000001AA;
  - crc_corr_o=1, end_bit_err_o=0.
- Same frame with CRC byte 0x89 (bad CRC) → crc_corr_o=0. With end bit 0 (byte 0x86) → end_bit_err_o=1, crc_corr_o=1.
- Long: arm with long_rsp_i=1, 136-bit frame of random CID with correct CRC7 →
  - rsp_o = R[127:8];
  - crc_corr_o=1;
  - rsp_valid_o exactly one enabled period after bit 0.
- clk_en_i 1-in-4 cycles, short frame as in the first scenario → identical results; rsp_valid_o high for 4 clk_i cycles.
- Mid-frame re-arm at bit 20 → no rsp_valid_o; the following full frame decodes correctly. rst_ni low mid-frame → all outputs 0 in the same cycle.
- Build without `SDHCI_RSP_CRC_CHECK_EN`, bad-CRC frame from the second scenario → crc_corr_o=1.

Source files
------------

// File: rtl/cmd_rsp_deserializer_if.sv
// Signal bundle between the CMD-line response deserializer (slave) and the
// command sequencer / pad side that drives it (master).
interface cmd_rsp_deserializer_if;
    logic         cmd_i;
    logic         long_rsp_i;
    logic         start_listening_i;
    logic         receiving_o;
    logic         rsp_valid_o;
    logic         end_bit_err_o;
    logic [119:0] rsp_o;
    logic         crc_corr_o;

    modport master (
        output cmd_i, long_rsp_i, start_listening_i,
        input  receiving_o, rsp_valid_o, end_bit_err_o, rsp_o, crc_corr_o
    );

    modport slave (
        input  cmd_i, long_rsp_i, start_listening_i,
        output receiving_o, rsp_valid_o, end_bit_err_o, rsp_o, crc_corr_o
    );
endinterface

// File: rtl/cmd_rsp_deserializer.sv
// SD CMD-line response deserializer: 48/136-bit frames, CRC7 and end-bit check.
// Optional macro SDHCI_RSP_CRC_CHECK_EN builds the CRC7 checker; otherwise crc_corr_o reports 1.
module cmd_rsp_deserializer (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clk_en_i,
    cmd_rsp_deserializer_if.slave bus,
    output logic [1:0]            state_o
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        RECEIVE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         long_q;
    logic [7:0]   cnt_q;
    logic [126:0] shift_q;
    logic         receiving_q, rsp_valid_q, end_bit_err_q, crc_corr_q;
    logic [119:0] rsp_q;
    logic         arm, start_seen, shift_en, frame_end;
    logic [7:0]   last_cnt;

`ifdef SDHCI_RSP_CRC_CHECK_EN
    logic [6:0] crc_q;
    logic       crc_en;

    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction
`endif

    // Count value at which the end bit (bit 0) is being sampled.
    assign last_cnt = long_q ? 8'd135 : 8'd47;

    always_comb begin
        state_d    = state_q;
        arm        = 1'b0;
        start_seen = 1'b0;
        shift_en   = 1'b0;
        frame_end  = 1'b0;
`ifdef SDHCI_RSP_CRC_CHECK_EN
        crc_en     = 1'b0;
`endif
        if (clk_en_i) begin
            if (bus.start_listening_i) begin
                state_d = WAIT_START;
                arm     = 1'b1;
            end else begin
                case (state_q)
                    IDLE: state_d = IDLE;
                    WAIT_START: begin
                        if (!bus.cmd_i) begin
                            state_d    = RECEIVE;
                            start_seen = 1'b1;
                        end
                    end
                    RECEIVE: begin
                        shift_en = 1'b1;
`ifdef SDHCI_RSP_CRC_CHECK_EN
                        // Sampled bit index is N-1-cnt; CRC covers indices down to 8 (and up to 127 for R2).
                        crc_en = long_q ? ((cnt_q >= 8'd8) && (cnt_q <= 8'd127))
                                        : (cnt_q <= 8'd39);
`endif
                        if (cnt_q == last_cnt) begin
                            frame_end = 1'b1;
                            state_d   = DONE;
                        end
                    end
                    DONE:    state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            long_q        <= 1'b0;
            cnt_q         <= 8'd0;
            shift_q       <= '0;
            receiving_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            end_bit_err_q <= 1'b0;
            crc_corr_q    <= 1'b0;
            rsp_q         <= '0;
`ifdef SDHCI_RSP_CRC_CHECK_EN
            crc_q         <= 7'd0;
`endif
        end else if (clk_en_i) begin
            state_q     <= state_d;
            receiving_q <= (state_d == RECEIVE);
            rsp_valid_q <= (state_d == DONE);
            if (arm) begin
                long_q        <= bus.long_rsp_i;
                cnt_q         <= 8'd0;
                shift_q       <= '0;
                rsp_q         <= '0;
                end_bit_err_q <= 1'b0;
                crc_corr_q    <= 1'b0;
`ifdef SDHCI_RSP_CRC_CHECK_EN
                crc_q         <= 7'd0;
`endif
            end else if (start_seen) begin
                // A zero start bit leaves a zero-seeded CRC unchanged, so it is not fed in.
                cnt_q   <= 8'd1;
                shift_q <= {shift_q[125:0], bus.cmd_i};
            end else if (shift_en) begin
                cnt_q   <= cnt_q + 8'd1;
                shift_q <= {shift_q[125:0], bus.cmd_i};
`ifdef SDHCI_RSP_CRC_CHECK_EN
                if (crc_en) crc_q <= crc7_step(crc_q, bus.cmd_i);
`endif
                if (frame_end) begin
                    // shift_q[k] holds frame bit k+1 while the end bit is on cmd_i.
                    rsp_q         <= long_q ? shift_q[126:7] : {82'd0, shift_q[44:7]};
                    end_bit_err_q <= ~bus.cmd_i;
`ifdef SDHCI_RSP_CRC_CHECK_EN
                    crc_corr_q    <= (shift_q[6:0] == crc_q);
`else
                    crc_corr_q    <= 1'b1;
`endif
                end
            end
        end
    end

    assign bus.receiving_o   = receiving_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.end_bit_err_o = end_bit_err_q;
    assign bus.rsp_o         = rsp_q;
    assign bus.crc_corr_o    = crc_corr_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_cmd_rsp_deserializer.sv
// Directed, table-driven bench for cmd_rsp_deserializer: short/long frames,
// CRC and end-bit errors, slow strobe, re-arm abort and asynchronous reset.
module tb_cmd_rsp_deserializer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_en;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    cmd_rsp_deserializer_if bus_if ();

    cmd_rsp_deserializer dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clk_en_i (clk_en),
        .bus      (bus_if.slave),
        .state_o  (dbg_state)
    );

`ifdef SDHCI_RSP_CRC_CHECK_EN
    localparam logic BAD_CRC_SEEN = 1'b0;
`else
    localparam logic BAD_CRC_SEEN = 1'b1;
`endif

    typedef struct {
        logic [135:0] frame;
        logic         lng;
        int           div;
        logic [119:0] exp_rsp;
        logic         exp_crc;
        logic         exp_end;
    } vec_t;

    vec_t         vecs[6];
    logic [119:0] exp_q[$];
    int           total = 0;
    int           bad = 0;

    // Cycle monitor: counts clk_i cycles with receiving/valid high and valid pulses.
    int   rcv_cyc = 0;
    int   val_cyc = 0;
    int   val_evt = 0;
    logic prev_val = 1'b0;

    always @(negedge clk) begin
        if (bus_if.receiving_o) rcv_cyc <= rcv_cyc + 1;
        if (bus_if.rsp_valid_o) val_cyc <= val_cyc + 1;
        if (bus_if.rsp_valid_o && !prev_val) val_evt <= val_evt + 1;
        prev_val <= bus_if.rsp_valid_o;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [119:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 119; i >= 0; i--) begin
            fb = c[6] ^ d[i];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // One sampling period of d clk_i cycles; strobe on the last, glitches on the others.
    task automatic en_cycle(input logic c, input logic sl, input int d);
        for (int j = 0; j < d; j++) begin
            clk_en                   = (j == d - 1);
            bus_if.cmd_i             = (j == d - 1) ? c  : 1'($urandom_range(0, 1));
            bus_if.start_listening_i = (j == d - 1) ? sl : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input string tag, input vec_t v);
        int n, r0, v0, e0;
        logic [119:0] exp;
        n = v.lng ? 136 : 48;
        exp_q.push_back(v.exp_rsp);
        bus_if.long_rsp_i = v.lng;
        en_cycle(1'b0, 1'b1, v.div);          // arm with CMD low: not a start bit
        bus_if.long_rsp_i = ~v.lng;           // must have been latched at arm
        for (int k = 0; k < 3; k++) en_cycle(1'b1, 1'b0, v.div);
        r0 = rcv_cyc; v0 = val_cyc; e0 = val_evt;
        for (int b = n - 1; b >= 0; b--) en_cycle(v.frame[b], 1'b0, v.div);
        check({tag, "_valid_latency"}, 128'(bus_if.rsp_valid_o), 128'd1);
        check({tag, "_rcv_fall"}, 128'(bus_if.receiving_o), 128'd0);
        for (int k = 0; k < 2; k++) en_cycle(1'b1, 1'b0, v.div);
        exp = exp_q.pop_front();
        check({tag, "_valid_events"}, 128'(val_evt - e0), 128'd1);
        check({tag, "_valid_cycles"}, 128'(val_cyc - v0), 128'(v.div));
        check({tag, "_rcv_cycles"}, 128'(rcv_cyc - r0), 128'((n - 1) * v.div));
        check({tag, "_rsp"}, 128'(bus_if.rsp_o), 128'(exp));
        check({tag, "_crc_corr"}, 128'(bus_if.crc_corr_o), 128'(v.exp_crc));
        check({tag, "_end_err"}, 128'(bus_if.end_bit_err_o), 128'(v.exp_end));
        check({tag, "_idle"}, 128'(dbg_state), 128'd0);
    endtask

    initial begin
        logic [119:0] cid;
        logic [135:0] fr;
        int           e0;

        // Clock/reset
        rst_n = 1'b0;
        clk_en = 1'b0;
        bus_if.cmd_i = 1'b1;
        bus_if.long_rsp_i = 1'b0;
        bus_if.start_listening_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_receiving", 128'(bus_if.receiving_o), 128'd0);
        check("rst_valid", 128'(bus_if.rsp_valid_o), 128'd0);
        check("rst_end_err", 128'(bus_if.end_bit_err_o), 128'd0);
        check("rst_rsp", 128'(bus_if.rsp_o), 128'd0);
        check("rst_crc", 128'(bus_if.crc_corr_o), 128'd0);
        check("rst_state", 128'(dbg_state), 128'd0);
        rst_n = 1'b1;

        // Vector table
        vecs[0] = '{{88'd0, 48'h48000001AA87}, 1'b0, 1, 120'h08000001AA, 1'b1, 1'b0};
        vecs[1] = '{{88'd0, 48'h48000001AA89}, 1'b0, 1, 120'h08000001AA, BAD_CRC_SEEN, 1'b0};
        vecs[2] = '{{88'd0, 48'h48000001AA86}, 1'b0, 1, 120'h08000001AA, 1'b1, 1'b1};
        cid = {$urandom, $urandom, $urandom, 24'($urandom)};
        vecs[3] = '{{8'h3F, cid, crc7_of(cid), 1'b1}, 1'b1, 1, cid, 1'b1, 1'b0};
        vecs[4] = '{{88'd0, 48'h48000001AA87}, 1'b0, 4, 120'h08000001AA, 1'b1, 1'b0};
        cid = {$urandom, $urandom, $urandom, 24'($urandom)};
        vecs[5] = '{{8'h3F, cid, ~crc7_of(cid), 1'b0}, 1'b1, 2, cid, BAD_CRC_SEEN, 1'b1};

        for (int i = 0; i < 6; i++) run_frame($sformatf("v%0d", i), vecs[i]);

        // Arm clears held results, re-arm at bit 20 aborts, next frame decodes.
        fr = vecs[0].frame;
        bus_if.long_rsp_i = 1'b0;
        en_cycle(1'b1, 1'b1, 1);
        check("arm_rsp_clr", 128'(bus_if.rsp_o), 128'd0);
        check("arm_end_clr", 128'(bus_if.end_bit_err_o), 128'd0);
        check("arm_crc_clr", 128'(bus_if.crc_corr_o), 128'd0);
        check("arm_state", 128'(dbg_state), 128'd1);
        en_cycle(1'b1, 1'b0, 1);
        e0 = val_evt;
        for (int b = 47; b >= 28; b--) en_cycle(fr[b], 1'b0, 1);
        check("abort_rcv_before", 128'(bus_if.receiving_o), 128'd1);
        en_cycle(1'b1, 1'b1, 1);
        check("abort_rcv_after", 128'(bus_if.receiving_o), 128'd0);
        check("abort_state", 128'(dbg_state), 128'd1);
        run_frame("rearm", vecs[0]);
        check("abort_no_valid", 128'(val_evt - e0), 128'd1);

        // Asynchronous reset mid-frame.
        fr = vecs[2].frame;
        en_cycle(1'b1, 1'b1, 1);
        en_cycle(1'b1, 1'b0, 1);
        for (int b = 47; b >= 18; b--) en_cycle(fr[b], 1'b0, 1);
        check("midrst_rcv_before", 128'(bus_if.receiving_o), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_receiving", 128'(bus_if.receiving_o), 128'd0);
        check("midrst_valid", 128'(bus_if.rsp_valid_o), 128'd0);
        check("midrst_rsp", 128'(bus_if.rsp_o), 128'd0);
        check("midrst_end_err", 128'(bus_if.end_bit_err_o), 128'd0);
        check("midrst_crc", 128'(bus_if.crc_corr_o), 128'd0);
        check("midrst_state", 128'(dbg_state), 128'd0);
        rst_n = 1'b1;
        for (int b = 17; b >= 0; b--) en_cycle(fr[b], 1'b0, 1);
        check("postrst_idle", 128'(dbg_state), 128'd0);
        run_frame("postrst", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
